vga_fb_reader: RTL and testbench
================================

// Module: vga_fb_reader
// PURPOSE
//  VGA scan-out engine: the read end of the dual-port frame-buffer RAM, which the core writes on port A.
//  Generates 640x480@60Hz timing and drives the 15-bit port-B read address.
//  Consumes the 16-bit read data (1 bpp, 16 pixels/word, MSB = leftmost) and emits sync plus 8-bit colour.
//  Sits between the memory controller's VGA port and the board VGA connector.
// PARAMETERS
//  CLK_DIV   2       clk cycles per pixel (50 MHz clk -> 25 MHz pixel); legal >= 2
//  H_VIS     640     visible pixels/line; H_FP 16, H_SYNC 96, H_BP 48 (H_TOTAL 800)
//  V_VIS     480     visible lines; V_FP 10, V_SYNC 2, V_BP 33 (V_TOTAL 525)
//  BASE_ADDR 15'd0   word address of pixel (0,0)
// PORTS
//  clk          in   1   system clock, also the RAM port-B clock
//  rst_n        in   1   asynchronous active-low reset
//  VGAAddress   out  15  port-B read word address
//  VGADataOut   in   16  port-B read data, valid 1 clk after address
//  fg_color     in   8   {R3,G3,B2} for pixel bit 1
//  bg_color     in   8   {R3,G3,B2} for pixel bit 0
//  hsync        out  1   horizontal sync, active low
//  vsync        out  1   vertical sync, active low
//  red          out  3   colour, 0 during blanking
//  green        out  3   colour, 0 during blanking
//  blue         out  2   colour, 0 during blanking
//  frame_start  out  1   1-clk pulse on the pixel tick with h=0,v=0
// BEHAVIOUR
//  Clock and reset
//  - One clock domain, clk. Reset is asynchronous and active-low on rst_n.
//  - Reset values: hsync=1, vsync=1, RGB=0, frame_start=0, VGAAddress=BASE_ADDR.
//  - Reset also clears the divider, h, v, line base and shift register.
//  - Release resumes at h=0,v=0; reset mid-frame abandons the frame with no partial-state carry-over.
//  Pixel tick
//  - Divider 0..CLK_DIV-1; tick = divider==CLK_DIV-1.
//  - h (10b) wraps 799->0; v (10b) advances when h wraps, wrapping 524->0.
//  Sync windows
//  - hsync low for h in 656..751; vsync low for v in 490..491.
//  - Visible when h<640 && v<480.
//  Pixel mapping
//  - Pixel (h,v) = bit 15-(h%16) of word BASE_ADDR + v*40 + h/16.
//  - No multiplier: the line base register adds 40 when h wraps on a visible line.
//  - Line base reloads BASE_ADDR at v wrap. Address width truncates modulo 2^15.
//  Fetch
//  - Word k of a line is addressed on the tick with h=16k-1; word 0 on the h=799 tick of the previous line.
//  - Data is latched 1 clk later into next_word.
//  - On the tick with h%16==0, next_word loads the shift register; each following tick shifts left by 1.
//  - No fetch on lines v>=480 except the h=799 tick of line 524, which prefetches row 0.
//  - VGAAddress holds its value between fetches.
//  Output
//  - hsync, vsync, RGB and frame_start are registered on the tick for (h,v) and are valid 1 clk later.
//  - All outputs keep the same latency, so sync and colour stay aligned.
//  - RGB = bit ? fg_color : bg_color when visible, else 0.
//  - fg_color and bg_color are sampled per pixel, so a change takes effect on the next tick.
//  Write collision
//  - A core write to the word being read returns old or new data per RAM behaviour; this block does not arbitrate.
// CONFIGURATION
//  VGA_PIXEL_DOUBLE_EN defined
//  - 320x240 buffer, each stored pixel shown as 2x2.
//  - Word = BASE_ADDR + (v>>1)*20 + (h>>5); bit = 15-((h>>1)%16).
//  - Shift on every second tick. Line base adds 20 only after odd visible lines.
//  - Fetch on ticks with h=32k-1 (word 0 at h=799).
//  VGA_PIXEL_DOUBLE_EN undefined
//  - 640x480 mapping as above; buffer uses 19200 words.
// TESTING
//  - Reset held 5 clk then released -> hsync=vsync=1, RGB=0, VGAAddress=BASE_ADDR until timing starts.
//  - Free run 1 frame -> hsync period 1600 clk with 192 clk low; vsync period 840000 clk with 3200 clk low; frame_start once per 840000 clk.
//  - RAM model: word n = n; fg=8'hFF, bg=8'h00 -> line 0 pixels 0..15 black, 16..30 black, 31 white; row 1 first address = 40.
//  - Word 0 = 16'h8001, fg=8'hE0 -> RGB=E0 at pixel 0 and pixel 15, 0 elsewhere in 0..15; no colour during h>=640 or v>=480.
//  - rst_n pulsed low at h=300,v=200 -> outputs reset asynchronously within the clk; next frame_start 840000 clk after release.
//  - With VGA_PIXEL_DOUBLE_EN, word 0=16'h8000 -> pixels (0,0),(1,0),(0,1),(1,1) coloured fg; row v=2 starts at address 20.

Source files
------------

// File: rtl/vga_fb_reader.sv
// VGA scan-out engine: 640x480@60 timing, 1 bpp frame-buffer fetch on RAM port B.
// Optional VGA_PIXEL_DOUBLE_EN shows a 320x240 buffer as 2x2 pixels.
module vga_fb_reader #(
   parameter int          CLK_DIV   = 2,
   parameter int          H_VIS     = 640,
   parameter int          H_FP      = 16,
   parameter int          H_SYNC    = 96,
   parameter int          H_BP      = 48,
   parameter int          V_VIS     = 480,
   parameter int          V_FP      = 10,
   parameter int          V_SYNC    = 2,
   parameter int          V_BP      = 33,
   parameter logic [14:0] BASE_ADDR = 15'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [14:0] VGAAddress,
   input  logic [15:0] VGADataOut,
   input  logic [7:0]  fg_color,
   input  logic [7:0]  bg_color,
   output logic        hsync,
   output logic        vsync,
   output logic [2:0]  red,
   output logic [2:0]  green,
   output logic [1:0]  blue,
   output logic        frame_start
);

`ifdef VGA_PIXEL_DOUBLE_EN
   localparam int          PSH = 5;
   localparam logic [14:0] WPL = 15'(H_VIS / 32);
`else
   localparam int          PSH = 4;
   localparam logic [14:0] WPL = 15'(H_VIS / 16);
`endif

   localparam int             DW       = $clog2(CLK_DIV);
   localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [9:0]     H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0]     V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0]     H_VIS_L  = 10'(H_VIS);
   localparam logic [9:0]     V_VIS_L  = 10'(V_VIS);
   localparam logic [9:0]     HS_BEG   = 10'(H_VIS + H_FP);
   localparam logic [9:0]     HS_END   = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0]     VS_BEG   = 10'(V_VIS + V_FP);
   localparam logic [9:0]     VS_END   = 10'(V_VIS + V_FP + V_SYNC);
   localparam logic [PSH-1:0] PMASK    = '1;

   logic [DW-1:0] div;
   logic [9:0]    h;
   logic [9:0]    v;
   logic [14:0]   line_base;
   logic [15:0]   next_word;
   logic [15:0]   shreg;
   logic          fetch_d;

   logic          tick;
   logic          h_wrap;
   logic          v_wrap;
   logic          row_vis;
   logic          vis;
   logic          word_start;
   logic          pix;
   logic          mid_fetch;
   logic          end_fetch;
   logic          fetch;
   logic [14:0]   step;
   logic [14:0]   base_nxt;
   logic [14:0]   fetch_addr;
   logic [15:0]   shreg_nxt;

   always_comb begin
      tick       = div == DIV_LAST;
      h_wrap     = h == H_LAST;
      v_wrap     = v == V_LAST;
      row_vis    = v < V_VIS_L;
      vis        = row_vis && (h < H_VIS_L);
      word_start = h[PSH-1:0] == '0;
      pix        = word_start ? next_word[15] : shreg[15];
      mid_fetch  = row_vis && (h[PSH-1:0] == PMASK) &&
                   (h < H_VIS_L - 10'd1);
      end_fetch  = h_wrap && ((v < V_VIS_L - 10'd1) || v_wrap);
      fetch      = mid_fetch || end_fetch;
`ifdef VGA_PIXEL_DOUBLE_EN
      // Line pairs share one buffer row; advance only after the odd line.
      step       = v[0] ? WPL : 15'd0;
      shreg_nxt  = word_start ? next_word :
                   (h[0] ? {shreg[14:0], 1'b0} : shreg);
`else
      step       = WPL;
      shreg_nxt  = word_start ? {next_word[14:0], 1'b0} :
                   {shreg[14:0], 1'b0};
`endif
      base_nxt   = v_wrap ? BASE_ADDR : line_base + step;
      fetch_addr = mid_fetch ?
                   line_base + 15'(h >> PSH) + 15'd1 : base_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div         <= '0;
         h           <= '0;
         v           <= '0;
         line_base   <= BASE_ADDR;
         shreg       <= '0;
         next_word   <= '0;
         // Reset address already points at word 0, so capture it at once.
         fetch_d     <= 1'b1;
         VGAAddress  <= BASE_ADDR;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         fetch_d     <= 1'b0;
         if (fetch_d)
            next_word <= VGADataOut;
         if (tick) begin
            div                <= '0;
            hsync              <= !((h >= HS_BEG) && (h < HS_END));
            vsync              <= !((v >= VS_BEG) && (v < VS_END));
            {red, green, blue} <= vis ? (pix ? fg_color : bg_color) : 8'd0;
            frame_start        <= (h == '0) && (v == '0);
            shreg              <= shreg_nxt;
            if (fetch) begin
               VGAAddress <= fetch_addr;
               fetch_d    <= 1'b1;
            end
            if (h_wrap) begin
               h <= '0;
               if (v_wrap) begin
                  v         <= '0;
                  line_base <= BASE_ADDR;
               end else begin
                  v <= v + 10'd1;
                  if (row_vis)
                     line_base <= line_base + step;
               end
            end else begin
               h <= h + 10'd1;
            end
         end else begin
            div <= div + DW'(1);
         end
      end
   end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Randomized self-checking bench for vga_fb_reader on a shrunken raster.
// Honours VGA_PIXEL_DOUBLE_EN the same way as the design.
module tb_vga_fb_reader;

   localparam int CD = 2;
   localparam int HV = 64, HF = 4, HS = 8, HB = 4;
   localparam int VV = 8, VF = 2, VS = 2, VB = 3;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME = HT * VT * CD;
   localparam logic [14:0] BASE = 15'h7FF0;
`ifdef VGA_PIXEL_DOUBLE_EN
   localparam int PW  = 32;
   localparam int WPL = HV / 32;
`else
   localparam int PW  = 16;
   localparam int WPL = HV / 16;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [14:0] addr;
   logic [15:0] rdata;
   logic [7:0]  fg = 8'd0;
   logic [7:0]  bg = 8'd0;
   logic        hsync, vsync, frame_start;
   logic [2:0]  red, green;
   logic [1:0]  blue;
   logic [7:0]  rgb;
   logic [15:0] mem [0:32767];
   int          ec;
   logic [7:0]  fg_t, bg_t;
   int          checks = 0;
   int          errors = 0;

   vga_fb_reader #(
      .CLK_DIV(CD), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .VGAAddress(addr), .VGADataOut(rdata),
      .fg_color(fg), .bg_color(bg), .hsync(hsync), .vsync(vsync),
      .red(red), .green(green), .blue(blue), .frame_start(frame_start)
   );

   always #5 clk = ~clk;
   assign rdata = mem[addr];
   assign rgb = {red, green, blue};

   // clocks since reset release, and colour inputs seen at each pixel tick
   always @(posedge clk or negedge rst_n)
      if (!rst_n) ec <= 0;
      else        ec <= ec + 1;

   always @(posedge clk)
      if (rst_n && ((ec + 1) % CD == 0)) begin
         fg_t <= fg;
         bg_t <= bg;
      end

   function automatic int word_of(int h, int v);
`ifdef VGA_PIXEL_DOUBLE_EN
      return (int'(BASE) + (v / 2) * WPL + h / 32) % 32768;
`else
      return (int'(BASE) + v * WPL + h / 16) % 32768;
`endif
   endfunction

   function automatic int bit_of(int h);
`ifdef VGA_PIXEL_DOUBLE_EN
      return 15 - ((h / 2) % 16);
`else
      return 15 - (h % 16);
`endif
   endfunction

   function automatic logic [7:0] rgb_at(int p, logic [7:0] f, logic [7:0] b);
      int h, v;
      if (p < 0) return 8'd0;
      h = p % HT;
      v = (p / HT) % VT;
      if (h >= HV || v >= VV) return 8'd0;
      return mem[word_of(h, v)][bit_of(h)] ? f : b;
   endfunction

   function automatic logic hs_at(int p);
      int h;
      if (p < 0) return 1'b1;
      h = p % HT;
      return !(h >= HV + HF && h < HV + HF + HS);
   endfunction

   function automatic logic vs_at(int p);
      int v;
      if (p < 0) return 1'b1;
      v = (p / HT) % VT;
      return !(v >= VV + VF && v < VV + VF + VS);
   endfunction

   function automatic logic fs_at(int e);
      if (e <= 0 || e % CD != 0) return 1'b0;
      return ((e / CD - 1) % (HT * VT)) == 0;
   endfunction

   task automatic wait_pix(input int h, input int v, output bit ok);
      int p;
      ok = 0;
      for (int n = 0; n < 2 * FRAME; n++) begin
         @(negedge clk);
         p = ec / CD - 1;
         if (ec > 0 && ec % CD == 0 && p % HT == h && (p / HT) % VT == v) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
      fg = 8'($urandom);
      bg = 8'($urandom);
      for (int n = 0; n < 6; n++) begin
         if (n == 5) rst_n = 1'b1;
         @(negedge clk);
         checks++;
         if ({hsync, vsync, rgb, frame_start, addr} !== {2'b11, 8'd0, 1'b0, BASE}) begin
            errors++;
            $display("FAIL reset n=%0d got hs=%b vs=%b rgb=%h fs=%b addr=%h exp 1 1 00 0 %h",
                     n, hsync, vsync, rgb, frame_start, addr, BASE);
         end
      end
   endtask

   task automatic test_free_run();
      int e, p, h, v, hn, vn, exp_addr;
      int hs_low, vs_low, fs_n, hs_f1, hs_f2, fs1, fs2;
      logic hs_prev;
      rst_n = 1'b0;
      for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_addr = int'(BASE);
      hs_low = 0; vs_low = 0; fs_n = 0;
      hs_f1 = -1; hs_f2 = -1; fs1 = -1; fs2 = -1;
      hs_prev = 1'b1;
      for (int n = 0; n < 2 * FRAME + CD; n++) begin
         @(negedge clk);
         e = ec;
         p = e / CD - 1;
         if (e > 0 && e % CD == 0 && p >= 0) begin
            h = p % HT;
            v = (p / HT) % VT;
            hn = (h + 1) % HT;
            vn = (h == HT - 1) ? (v + 1) % VT : v;
            if (hn % PW == 0 && hn < HV && vn < VV) exp_addr = word_of(hn, vn);
         end
         checks++;
         if (rgb !== rgb_at(p, fg_t, bg_t)) begin
            errors++;
            if (errors < 20) $display("FAIL run_rgb e=%0d got %h exp %h", e, rgb, rgb_at(p, fg_t, bg_t));
         end
         checks++;
         if ({hsync, vsync, frame_start} !== {hs_at(p), vs_at(p), fs_at(e)}) begin
            errors++;
            if (errors < 20) $display("FAIL run_sync e=%0d got %b%b%b exp %b%b%b", e,
                                      hsync, vsync, frame_start, hs_at(p), vs_at(p), fs_at(e));
         end
         checks++;
         if (addr !== 15'(exp_addr)) begin
            errors++;
            if (errors < 20) $display("FAIL run_addr e=%0d got %h exp %h", e, addr, 15'(exp_addr));
         end
         if (e >= CD && e < CD + FRAME) begin
            hs_low += (hsync === 1'b0) ? 1 : 0;
            vs_low += (vsync === 1'b0) ? 1 : 0;
            fs_n   += (frame_start === 1'b1) ? 1 : 0;
         end
         if (hs_prev === 1'b1 && hsync === 1'b0) begin
            if (hs_f1 < 0) hs_f1 = e;
            else if (hs_f2 < 0) hs_f2 = e;
         end
         hs_prev = hsync;
         if (frame_start === 1'b1) begin
            if (fs1 < 0) fs1 = e;
            else if (fs2 < 0) fs2 = e;
         end
         fg = 8'($urandom);
         bg = 8'($urandom);
      end
      checks++;
      if (hs_low != HS * CD * VT) begin
         errors++;
         $display("FAIL hsync_low got %0d exp %0d", hs_low, HS * CD * VT);
      end
      checks++;
      if (vs_low != VS * HT * CD) begin
         errors++;
         $display("FAIL vsync_low got %0d exp %0d", vs_low, VS * HT * CD);
      end
      checks++;
      if (fs_n != 1) begin
         errors++;
         $display("FAIL fs_count got %0d exp 1", fs_n);
      end
      checks++;
      if (hs_f1 < 0 || hs_f2 - hs_f1 != HT * CD) begin
         errors++;
         $display("FAIL hsync_period got %0d exp %0d", hs_f2 - hs_f1, HT * CD);
      end
      checks++;
      if (fs1 != CD || fs2 - fs1 != FRAME) begin
         errors++;
         $display("FAIL frame_period got first=%0d period=%0d exp %0d %0d", fs1, fs2 - fs1, CD, FRAME);
      end
   endtask

`ifndef VGA_PIXEL_DOUBLE_EN
   task automatic test_ramp();
      bit ok;
      logic [7:0] exp;
      rst_n = 1'b0;
      for (int i = 0; i < 32768; i++) mem[i] = 16'((i - int'(BASE)) & 32'h7FFF);
      fg = 8'hFF;
      bg = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int h = 0; h < 32; h++) begin
         wait_pix(h, 0, ok);
         exp = (h == 31) ? 8'hFF : 8'h00;
         checks++;
         if (!ok || rgb !== exp) begin
            errors++;
            $display("FAIL ramp_pix h=%0d ok=%0d got %h exp %h", h, ok, rgb, exp);
         end
         if (h == 15 || h == 31) begin
            checks++;
            if (addr !== BASE + 15'((h + 1) / 16)) begin
               errors++;
               $display("FAIL ramp_addr h=%0d got %h exp %h", h, addr, BASE + 15'((h + 1) / 16));
            end
         end
      end
      wait_pix(HT - 1, 0, ok);
      checks++;
      if (!ok || addr !== BASE + 15'(WPL)) begin
         errors++;
         $display("FAIL row1_addr got %h exp %h", addr, BASE + 15'(WPL));
      end
   endtask

   task automatic test_pattern();
      bit ok;
      int p, h, v;
      logic [7:0] exp;
      rst_n = 1'b0;
      for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
      mem[BASE] = 16'h8001;
      fg = 8'hE0;
      bg = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int hh = 0; hh < 16; hh++) begin
         wait_pix(hh, 0, ok);
         exp = (hh == 0 || hh == 15) ? 8'hE0 : 8'h00;
         checks++;
         if (!ok || rgb !== exp) begin
            errors++;
            $display("FAIL pattern h=%0d ok=%0d got %h exp %h", hh, ok, rgb, exp);
         end
      end
      bg = 8'h1F;
      while (ec < FRAME + CD) begin
         @(negedge clk);
         p = ec / CD - 1;
         h = p % HT;
         v = (p / HT) % VT;
         if (ec % CD == 0 && (h >= HV || v >= VV)) begin
            checks++;
            if (rgb !== 8'h00) begin
               errors++;
               if (errors < 20) $display("FAIL blank h=%0d v=%0d got %h exp 00", h, v, rgb);
            end
         end
      end
   endtask
`else
   task automatic test_double();
      bit ok;
      rst_n = 1'b0;
      for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
      mem[BASE] = 16'h8000;
      fg = 8'hE3;
      bg = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int v = 0; v < 2; v++) begin
         for (int h = 0; h < 3; h++) begin
            wait_pix(h, v, ok);
            checks++;
            if (!ok || rgb !== ((h < 2) ? 8'hE3 : 8'h00)) begin
               errors++;
               $display("FAIL dbl_pix h=%0d v=%0d got %h exp %h", h, v, rgb, (h < 2) ? 8'hE3 : 8'h00);
            end
         end
         wait_pix(HT - 1, v, ok);
         checks++;
         if (!ok || addr !== BASE + 15'(v * WPL)) begin
            errors++;
            $display("FAIL dbl_addr v=%0d got %h exp %h", v, addr, BASE + 15'(v * WPL));
         end
      end
   endtask
`endif

   task automatic test_mid_reset();
      bit ok;
      int f1, f2;
      fg = 8'hFF;
      bg = 8'hFF;
      wait_pix(30, 5, ok);
      checks++;
      if (!ok || rgb !== 8'hFF) begin
         errors++;
         $display("FAIL pre_reset ok=%0d got %h exp ff", ok, rgb);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({hsync, vsync, rgb, frame_start, addr} !== {2'b11, 8'd0, 1'b0, BASE}) begin
         errors++;
         $display("FAIL async_reset got hs=%b vs=%b rgb=%h fs=%b addr=%h exp 1 1 00 0 %h",
                  hsync, vsync, rgb, frame_start, addr, BASE);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      f1 = -1;
      f2 = -1;
      for (int n = 0; n < 3 * FRAME && f2 < 0; n++) begin
         @(negedge clk);
         if (frame_start === 1'b1) begin
            if (f1 < 0) f1 = ec;
            else f2 = ec;
         end
      end
      checks++;
      if (f1 != CD || f2 - f1 != FRAME) begin
         errors++;
         $display("FAIL restart_frame got first=%0d period=%0d exp %0d %0d", f1, f2 - f1, CD, FRAME);
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
`ifndef VGA_PIXEL_DOUBLE_EN
      test_ramp();
      test_pattern();
`else
      test_double();
`endif
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
